// File: rtl/smc_lite_pkg12.sv
// Shared types and default widths for the lite SMC read strobe path.
//   DEF_*      : default parameter widths for the read strobe generator
//   ALL_LANES  : lane mask used when a request asks for "all lanes" (be == 0)
//   state_e    : read access phases
package smc_lite_pkg12;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_SETUP_W = 2;
  localparam int unsigned DEF_WAIT_W  = 5;
  localparam int unsigned DEF_HOLD_W  = 2;
  localparam int unsigned DEF_LANES   = DEF_DATA_W / 8;

  localparam logic [DEF_LANES-1:0] ALL_LANES = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/smc_phase_cnt12.sv
// Loadable down-counter shared by the setup, strobe and hold phases.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load load_val_i this cycle (phase entry)
//   load_val_i   : phase length minus one
//   zero_o       : registered flag, high while the count is zero (last phase cycle)
module smc_phase_cnt12 #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/smc_rd_strobe_lite12.sv
// Read-side strobe generator and data capture for the lite static memory controller.
//   hclk12, sys_reset12     : clock, synchronous active-high reset
//   r_rd_start12/abort12    : request / terminate from the SMC state machine
//   r_setup12/wait12/hold12 : phase timing, latched at start
//   r_be12                  : byte lanes to read (0 = all)
//   data_smc12              : external data bus
//   smc_n_oe12, smc_n_rd12  : active-low output enable and per-lane read strobes
//   rd_data12, rd_valid12   : masked captured word and its one-cycle valid pulse
//   rd_busy12               : access in progress
module smc_rd_strobe_lite12
  import smc_lite_pkg12::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned SETUP_W = DEF_SETUP_W,
  parameter int unsigned WAIT_W  = DEF_WAIT_W,
  parameter int unsigned HOLD_W  = DEF_HOLD_W
) (
  input  logic                hclk12,
  input  logic                sys_reset12,
  input  logic                r_rd_start12,
  input  logic                r_rd_abort12,
  input  logic [SETUP_W-1:0]  r_setup12,
  input  logic [WAIT_W-1:0]   r_wait12,
  input  logic [HOLD_W-1:0]   r_hold12,
  input  logic [DATA_W/8-1:0] r_be12,
  input  logic [DATA_W-1:0]   data_smc12,
  output logic                smc_n_oe12,
  output logic [DATA_W/8-1:0] smc_n_rd12,
  output logic [DATA_W-1:0]   rd_data12,
  output logic                rd_valid12,
  output logic                rd_busy12
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned CNT_W0 = (SETUP_W > WAIT_W) ? SETUP_W : WAIT_W;
  localparam int unsigned CNT_W  = (CNT_W0 > HOLD_W) ? CNT_W0 : HOLD_W;

  state_e             state_q, state_d;
  logic [SETUP_W-1:0] setup_q, setup_d;
  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic [HOLD_W-1:0]  hold_q,  hold_d;
  logic [LANES-1:0]   be_q,    be_d;
  logic               n_oe_q,  n_oe_d;
  logic [LANES-1:0]   n_rd_q,  n_rd_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               busy_q,  busy_d;

  logic               accept_c;
  logic               capture_c;
  logic               cnt_load_c;
  logic [CNT_W-1:0]   cnt_val_c;
  logic               cnt_zero;

  // A start is taken only from IDLE and never alongside an abort.
  assign accept_c = (state_q == ST_IDLE) && r_rd_start12 && !r_rd_abort12;

  // Access configuration latch; later config changes are ignored.
  always_comb begin
    setup_d = setup_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    be_d    = be_q;
    if (accept_c) begin
      setup_d = r_setup12;
      wait_d  = r_wait12;
      hold_d  = r_hold12;
      be_d    = (r_be12 == '0) ? {LANES{1'b1}} : r_be12;
    end
  end

  // Phase sequencing; each phase entry reloads the shared counter with length-1.
  always_comb begin
    state_d    = state_q;
    cnt_load_c = 1'b0;
    cnt_val_c  = '0;
    capture_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cnt_load_c = 1'b1;
          if (setup_d != '0) begin
            state_d   = ST_SETUP;
            cnt_val_c = CNT_W'(setup_d - SETUP_W'(1));
          end else begin
            state_d   = ST_STROBE;
            cnt_val_c = CNT_W'(wait_d);
          end
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d    = ST_STROBE;
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(wait_q);
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          capture_c = 1'b1;
          if (hold_q != '0) begin
            state_d    = ST_HOLD;
            cnt_load_c = 1'b1;
            cnt_val_c  = CNT_W'(hold_q - HOLD_W'(1));
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a capture on the last strobe cycle.
    if (r_rd_abort12 && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      cnt_load_c = 1'b0;
      capture_c  = 1'b0;
    end
  end

  // Pin and status values derived from the next state so the outputs stay registered.
  always_comb begin
    n_oe_d     = (state_d != ST_STROBE);
    n_rd_d     = (state_d == ST_STROBE) ? ~be_d : {LANES{1'b1}};
    busy_d     = (state_d != ST_IDLE);
    rd_valid_d = capture_c;
    rd_data_d  = rd_data_q;
    if (capture_c) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        rd_data_d[8*i +: 8] = be_q[i] ? data_smc12[8*i +: 8] : 8'h00;
      end
    end
  end

  always_ff @(posedge hclk12) begin
    if (sys_reset12) begin
      state_q    <= ST_IDLE;
      setup_q    <= '0;
      wait_q     <= '0;
      hold_q     <= '0;
      be_q       <= '0;
      n_oe_q     <= 1'b1;
      n_rd_q     <= '1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      setup_q    <= setup_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      be_q       <= be_d;
      n_oe_q     <= n_oe_d;
      n_rd_q     <= n_rd_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  smc_phase_cnt12 #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk_i      (hclk12),
    .rst_i      (sys_reset12),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_val_c),
    .zero_o     (cnt_zero)
  );

  assign smc_n_oe12 = n_oe_q;
  assign smc_n_rd12 = n_rd_q;
  assign rd_data12  = rd_data_q;
  assign rd_valid12 = rd_valid_q;
  assign rd_busy12  = busy_q;

endmodule

// File: tb/tb_smc_rd_strobe_lite12.sv
// Directed bench for smc_rd_strobe_lite12 with a queue-based data scoreboard.
module tb_smc_rd_strobe_lite12;

  logic        clk = 1'b0;
  logic        sys_reset12;
  logic        r_rd_start12;
  logic        r_rd_abort12;
  logic [1:0]  r_setup12;
  logic [4:0]  r_wait12;
  logic [1:0]  r_hold12;
  logic [3:0]  r_be12;
  logic [31:0] data_smc12;
  logic        smc_n_oe12;
  logic [3:0]  smc_n_rd12;
  logic [31:0] rd_data12;
  logic        rd_valid12;
  logic        rd_busy12;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  smc_rd_strobe_lite12 dut (
    .hclk12       (clk),
    .sys_reset12  (sys_reset12),
    .r_rd_start12 (r_rd_start12),
    .r_rd_abort12 (r_rd_abort12),
    .r_setup12    (r_setup12),
    .r_wait12     (r_wait12),
    .r_hold12     (r_hold12),
    .r_be12       (r_be12),
    .data_smc12   (data_smc12),
    .smc_n_oe12   (smc_n_oe12),
    .smc_n_rd12   (smc_n_rd12),
    .rd_data12    (rd_data12),
    .rd_valid12   (rd_valid12),
    .rd_busy12    (rd_busy12)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse is matched against the oldest expected word.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rd_valid12 === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got rd_data %h with no read outstanding", rd_data12);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data12, e);
        end
      end
    end
  end

  // One access: start driven in cycle 0, outputs observed in cycles 1..win.
  // exp_vcyc=0 means no valid pulse; event cycles of -1 are unused.
  task automatic run_read(input string tag, input logic [1:0] su, input logic [4:0] wt,
                          input logic [1:0] hd, input logic [3:0] be, input logic [31:0] dat,
                          input logic [31:0] exp_data, input logic [3:0] exp_nrd,
                          input int exp_oe, input int exp_busy, input int exp_vcyc,
                          input int xstart_cyc, input int abort_cyc, input int reset_cyc,
                          input int win);
    int oe_cnt, busy_cnt, v_cnt, v_cyc;
    logic [3:0] nrd_seen;
    oe_cnt = 0; busy_cnt = 0; v_cnt = 0; v_cyc = 0;
    nrd_seen = exp_nrd;
    if (exp_vcyc > 0) exp_q.push_back(exp_data);
    @(negedge clk);
    r_setup12    = su;
    r_wait12     = wt;
    r_hold12     = hd;
    r_be12       = be;
    data_smc12   = dat;
    r_rd_start12 = 1'b1;
    r_rd_abort12 = (abort_cyc == 0);
    for (int cyc = 1; cyc <= win; cyc++) begin
      @(negedge clk);
      if (smc_n_oe12 === 1'b0) begin
        oe_cnt++;
        if (smc_n_rd12 !== exp_nrd) nrd_seen = smc_n_rd12;
      end
      if (rd_busy12 === 1'b1) busy_cnt++;
      if (rd_valid12 === 1'b1) begin
        v_cnt++;
        v_cyc = cyc;
      end
      if ((abort_cyc >= 0 && cyc == abort_cyc + 1) || (reset_cyc >= 0 && cyc == reset_cyc + 1)) begin
        chk({tag, "_evt_n_oe"},  32'(smc_n_oe12), 32'd1);
        chk({tag, "_evt_n_rd"},  32'(smc_n_rd12), 32'hF);
        chk({tag, "_evt_busy"},  32'(rd_busy12),  32'd0);
        chk({tag, "_evt_valid"}, 32'(rd_valid12), 32'd0);
        if (reset_cyc >= 0) chk({tag, "_evt_rd_data"}, rd_data12, 32'h0);
      end
      r_rd_start12 = (cyc == xstart_cyc);
      if (cyc == xstart_cyc) r_wait12 = 5'd7;
      r_rd_abort12 = (cyc == abort_cyc);
      sys_reset12  = (cyc == reset_cyc);
    end
    chk({tag, "_oe_cycles"},   32'(oe_cnt),   32'(exp_oe));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, "_valid_count"}, 32'(v_cnt),    (exp_vcyc > 0) ? 32'd1 : 32'd0);
    if (exp_vcyc > 0) chk({tag, "_valid_cycle"}, 32'(v_cyc), 32'(exp_vcyc));
    if (exp_oe > 0)   chk({tag, "_n_rd"},        32'(nrd_seen), 32'(exp_nrd));
    chk({tag, "_rd_data_held"}, rd_data12, exp_data);
  endtask

  initial begin
    sys_reset12  = 1'b1;
    r_rd_start12 = 1'b0;
    r_rd_abort12 = 1'b0;
    r_setup12    = '0;
    r_wait12     = '0;
    r_hold12     = '0;
    r_be12       = '0;
    data_smc12   = '0;
    repeat (2) @(negedge clk);
    chk("reset_n_oe",  32'(smc_n_oe12), 32'd1);
    chk("reset_n_rd",  32'(smc_n_rd12), 32'hF);
    chk("reset_data",  rd_data12,       32'h0);
    chk("reset_valid", 32'(rd_valid12), 32'd0);
    chk("reset_busy",  32'(rd_busy12),  32'd0);
    sys_reset12 = 1'b0;

    //        tag        su    wt     hd    be       data           exp_data       nrd      oe busy vcyc xst abt rst win
    run_read("zero",     2'd0, 5'd0,  2'd0, 4'hF,    32'hA5A5_1234, 32'hA5A5_1234, 4'h0,    1, 1,   2,  -1, -1, -1, 20);
    run_read("timed",    2'd2, 5'd3,  2'd1, 4'b0101, 32'hDEAD_BEEF, 32'h00AD_00EF, 4'b1010, 4, 7,   7,  -1, -1, -1, 20);
    run_read("be0",      2'd1, 5'd1,  2'd0, 4'h0,    32'h1357_9BDF, 32'h1357_9BDF, 4'h0,    2, 3,   4,   2, -1, -1, 20);
    run_read("maxwait",  2'd0, 5'd31, 2'd0, 4'b0010, 32'h1122_3344, 32'h0000_3300, 4'b1101, 32, 32, 33, -1, -1, -1, 40);
    run_read("abort",    2'd0, 5'd3,  2'd0, 4'hF,    32'hFFFF_FFFF, 32'h0000_3300, 4'h0,    2, 2,   0,  -1,  2, -1, 20);
    run_read("abortst",  2'd1, 5'd2,  2'd1, 4'hF,    32'hFFFF_FFFF, 32'h0000_3300, 4'h0,    0, 0,   0,  -1,  0, -1, 20);
    run_read("rstmid",   2'd0, 5'd5,  2'd0, 4'hF,    32'h5555_AAAA, 32'h0000_0000, 4'h0,    2, 2,   0,  -1, -1,  2, 20);
    run_read("afterrst", 2'd1, 5'd0,  2'd2, 4'b1000, 32'hCAFE_F00D, 32'hCA00_0000, 4'b0111, 1, 4,   3,  -1, -1, -1, 20);

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
